if_stage: RTL and testbench

- Instruction-fetch stage of the RV32IM pipeline. It owns the PC, issues reads to the instruction cache, and drives the IF/ID pipeline register consumed by the decode/control stage.
- It absorbs instruction-cache misses (ICACHE_BUSY), pipeline stalls (STALL) and taken-branch redirects from EX.
- A one-entry skid buffer ensures a completed fetch is never lost or re-requested.

---
 rtl/if_stage.sv | 149 ++++++++++++++
 tb/tb_if_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, requests words from the instruction cache
// and loads the IF/ID register, with a one-entry skid buffer for fetches completed under stall.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        ICACHE_READ,
    output logic [31:0] ICACHE_ADDR,
    input  logic [31:0] ICACHE_INSTR,
    input  logic        ICACHE_BUSY,
    output logic [31:0] PC,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_INSTR,
    output logic        IFID_VALID
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] tgt_reg, tgt_nxt;
    logic        buf_valid, buf_valid_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic [31:0] ifid_pc_nxt, ifid_pc4_nxt, ifid_instr_nxt;
    logic        ifid_valid_nxt;
    logic        fetch_done;
    logic        redirect;

    assign ICACHE_ADDR = PC;
    assign ICACHE_READ = RESET && (state != IDLE) && !buf_valid;
    assign fetch_done  = ICACHE_READ && !ICACHE_BUSY;
    assign pc_plus4    = PC + 32'd4;
    assign target      = {BRANCH_TARGET[31:2], 2'b00};
    assign redirect    = BRANCH_TAKEN && !STALL;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = PC;
        tgt_nxt        = tgt_reg;
        buf_valid_nxt  = buf_valid;
        buf_pc_nxt     = buf_pc;
        buf_instr_nxt  = buf_instr;
        ifid_pc_nxt    = IFID_PC;
        ifid_pc4_nxt   = IFID_PC4;
        ifid_instr_nxt = IFID_INSTR;
        ifid_valid_nxt = IFID_VALID;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end

            FETCH: begin
                if (redirect) begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = NOP_INSTR;
                    buf_valid_nxt  = 1'b0;
                    // A miss in flight must complete at the old address before retargeting.
                    if (ICACHE_READ && ICACHE_BUSY) begin
                        tgt_nxt   = target;
                        state_nxt = DRAIN;
                    end else begin
                        pc_nxt = target;
                    end
                end else if (STALL) begin
                    if (fetch_done) begin
                        buf_valid_nxt = 1'b1;
                        buf_pc_nxt    = PC;
                        buf_instr_nxt = ICACHE_INSTR;
                        pc_nxt        = pc_plus4;
                    end
                end else if (buf_valid) begin
                    ifid_pc_nxt    = buf_pc;
                    ifid_pc4_nxt   = buf_pc + 32'd4;
                    ifid_instr_nxt = buf_instr;
                    ifid_valid_nxt = 1'b1;
                    buf_valid_nxt  = 1'b0;
                end else if (fetch_done) begin
                    ifid_pc_nxt    = PC;
                    ifid_pc4_nxt   = pc_plus4;
                    ifid_instr_nxt = ICACHE_INSTR;
                    ifid_valid_nxt = 1'b1;
                    pc_nxt         = pc_plus4;
                end else begin
                    ifid_valid_nxt = 1'b0;
                end
            end

            DRAIN: begin
                if (!STALL) begin
                    ifid_valid_nxt = 1'b0;
                end
                if (redirect) begin
                    tgt_nxt        = target;
                    ifid_instr_nxt = NOP_INSTR;
                end
                // The newest redirect wins even if it lands on the cycle the miss completes.
                if (!ICACHE_BUSY) begin
                    pc_nxt    = redirect ? target : tgt_reg;
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            PC         <= RESET_PC;
            tgt_reg    <= '0;
            buf_valid  <= 1'b0;
            buf_pc     <= '0;
            buf_instr  <= '0;
            IFID_PC    <= '0;
            IFID_PC4   <= 32'd4;
            IFID_INSTR <= NOP_INSTR;
            IFID_VALID <= 1'b0;
        end else begin
            state      <= state_nxt;
            PC         <= pc_nxt;
            tgt_reg    <= tgt_nxt;
            buf_valid  <= buf_valid_nxt;
            buf_pc     <= buf_pc_nxt;
            buf_instr  <= buf_instr_nxt;
            IFID_PC    <= ifid_pc_nxt;
            IFID_PC4   <= ifid_pc4_nxt;
            IFID_INSTR <= ifid_instr_nxt;
            IFID_VALID <= ifid_valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by a randomized run checked
// against an in-order program-stream model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET, STALL, BRANCH_TAKEN, ICACHE_BUSY;
    logic [31:0] BRANCH_TARGET;
    logic        ICACHE_READ;
    logic [31:0] ICACHE_ADDR, ICACHE_INSTR;
    logic [31:0] PC, IFID_PC, IFID_PC4, IFID_INSTR;
    logic        IFID_VALID;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0F0F_1234;
    endfunction

    assign ICACHE_INSTR = ICACHE_BUSY ? 32'hDEAD_BEEF : mem(ICACHE_ADDR);

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .STALL        (STALL),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .ICACHE_READ  (ICACHE_READ),
        .ICACHE_ADDR  (ICACHE_ADDR),
        .ICACHE_INSTR (ICACHE_INSTR),
        .ICACHE_BUSY  (ICACHE_BUSY),
        .PC           (PC),
        .IFID_PC      (IFID_PC),
        .IFID_PC4     (IFID_PC4),
        .IFID_INSTR   (IFID_INSTR),
        .IFID_VALID   (IFID_VALID)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] p);
        chk({tag, "_valid"}, {31'b0, IFID_VALID}, 32'd1);
        chk({tag, "_pc"}, IFID_PC, p);
        chk({tag, "_pc4"}, IFID_PC4, p + 32'd4);
        chk({tag, "_instr"}, IFID_INSTR, mem(p));
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'b0, IFID_VALID}, 32'd0);
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    // Random-phase reference: the in-order instruction stream the stage should deliver
    logic [31:0] exp_next, m_pc, m_instr, tgt, l_tgt;
    logic        m_valid, pend, l_stall, l_br;
    int unsigned delivered;

    initial begin
        RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0;
        BRANCH_TARGET = '0; ICACHE_BUSY = 1'b0;

        // Reset state
        tick; tick;
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", {31'b0, IFID_VALID}, 32'd0);
        chk("rst_instr", IFID_INSTR, NOP);
        chk("rst_ifid_pc", IFID_PC, 32'h0);
        chk("rst_ifid_pc4", IFID_PC4, 32'd4);
        chk("rst_read", {31'b0, ICACHE_READ}, 32'd0);

        // Release: one IDLE cycle without a request, then a hit stream
        RESET = 1'b1;
        chk("idle_read", {31'b0, ICACHE_READ}, 32'd0);
        tick;
        chk("fetch_read", {31'b0, ICACHE_READ}, 32'd1);
        chk_bubble("idle_bubble");
        tick; chk_ifid("hit0", 32'h0);
        tick; chk_ifid("hit4", 32'h4);
        chk("pc_before_miss", PC, 32'h8);

        // Miss at 0x8 for three cycles
        ICACHE_BUSY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("miss_addr", ICACHE_ADDR, 32'h8);
            chk_bubble("miss_bubble");
        end
        ICACHE_BUSY = 1'b0;
        tick; chk_ifid("miss_ret8", 32'h8);
        tick; chk_ifid("hit_c", 32'hC);
        chk("pc_before_stall", PC, 32'h10);

        // Stall two cycles at 0x10: 0x10 goes to the skid buffer
        STALL = 1'b1;
        tick; chk_ifid("stall1_hold", 32'hC); chk("stall1_pc", PC, 32'h14);
        chk("stall2_read", {31'b0, ICACHE_READ}, 32'd0);
        tick; chk_ifid("stall2_hold", 32'hC);
        chk("stall2_read_low", {31'b0, ICACHE_READ}, 32'd0);
        STALL = 1'b0;
        tick; chk_ifid("skid_10", 32'h10); chk("skid_pc", PC, 32'h14);
        tick; chk_ifid("after_14", 32'h14);
        tick; chk_ifid("after_18", 32'h18);
        tick; chk_ifid("after_1c", 32'h1C);
        chk("pc_before_br", PC, 32'h20);

        // Branch on hit, unaligned target
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h203;
        tick;
        chk_bubble("br_bubble");
        chk("br_nop", IFID_INSTR, NOP);
        chk("br_pc", PC, 32'h200);
        BRANCH_TAKEN = 1'b0;
        tick; chk_ifid("br_200", 32'h200);

        // Move to 0x30, then branch while the fetch there misses
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h30;
        tick; chk("to30_pc", PC, 32'h30);
        ICACHE_BUSY = 1'b1; BRANCH_TARGET = 32'h100;
        tick;
        chk("drain_addr1", ICACHE_ADDR, 32'h30);
        chk("drain_read1", {31'b0, ICACHE_READ}, 32'd1);
        chk_bubble("drain_bubble1");
        BRANCH_TAKEN = 1'b0;
        tick;
        chk("drain_addr2", ICACHE_ADDR, 32'h30);
        chk_bubble("drain_bubble2");
        ICACHE_BUSY = 1'b0;
        tick;
        chk_bubble("drain_discard");
        chk("drain_pc", PC, 32'h100);
        tick; chk_ifid("drain_100", 32'h100);

        // Wrap at the top of the address space
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFE;
        tick; chk("wrap_pc_top", PC, 32'hFFFF_FFFC);
        BRANCH_TAKEN = 1'b0;
        tick;
        chk_ifid("wrap_fetch", 32'hFFFF_FFFC);
        chk("wrap_pc4", IFID_PC4, 32'h0);
        chk("wrap_pc", PC, 32'h0);

        // Reset during a miss
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40;
        tick; BRANCH_TAKEN = 1'b0; ICACHE_BUSY = 1'b1;
        tick; chk("miss40_pc", PC, 32'h40);
        RESET = 1'b0;
        tick;
        chk("mrst_pc", PC, 32'h0);
        chk_bubble("mrst_bubble");
        chk("mrst_instr", IFID_INSTR, NOP);
        chk("mrst_read", {31'b0, ICACHE_READ}, 32'd0);
        RESET = 1'b1; ICACHE_BUSY = 1'b0;
        tick; chk("mrst_read_after", {31'b0, ICACHE_READ}, 32'd1);

        // Reset with a full skid buffer: buffer must be empty afterwards
        STALL = 1'b1;
        tick; chk("bfull_read", {31'b0, ICACHE_READ}, 32'd0); chk("bfull_pc", PC, 32'h4);
        RESET = 1'b0;
        tick; chk("brst_pc", PC, 32'h0);
        RESET = 1'b1; STALL = 1'b0;
        tick; chk("brst_read", {31'b0, ICACHE_READ}, 32'd1);
        tick; chk_ifid("brst_0", 32'h0);
        tick; chk_ifid("brst_4", 32'h4);

        // Randomized phase
        exp_next = 32'h8; m_valid = 1'b1; m_pc = 32'h4; m_instr = mem(32'h4);
        pend = 1'b0; tgt = '0; delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            STALL       = ($urandom_range(3) == 0);
            ICACHE_BUSY = ($urandom_range(2) == 0);
            if (!pend && $urandom_range(9) == 0) begin
                pend = 1'b1;
                tgt  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : $urandom;
            end
            BRANCH_TAKEN  = pend;
            BRANCH_TARGET = tgt;
            l_stall = STALL; l_br = pend; l_tgt = tgt;
            if (!STALL) pend = 1'b0;
            tick;
            chk("r_addr_align", {30'b0, ICACHE_ADDR[1:0]}, 32'd0);
            if (l_stall) begin
                chk("r_hold_valid", {31'b0, IFID_VALID}, {31'b0, m_valid});
                if (m_valid) begin
                    chk("r_hold_pc", IFID_PC, m_pc);
                    chk("r_hold_instr", IFID_INSTR, m_instr);
                end
            end else if (l_br) begin
                chk("r_br_valid", {31'b0, IFID_VALID}, 32'd0);
                chk("r_br_nop", IFID_INSTR, NOP);
                m_valid  = 1'b0;
                exp_next = {l_tgt[31:2], 2'b00};
            end else if (IFID_VALID) begin
                chk("r_pc", IFID_PC, exp_next);
                chk("r_pc4", IFID_PC4, exp_next + 32'd4);
                chk("r_instr", IFID_INSTR, mem(exp_next));
                m_valid  = 1'b1;
                m_pc     = exp_next;
                m_instr  = mem(exp_next);
                exp_next = exp_next + 32'd4;
                delivered++;
            end else begin
                m_valid = 1'b0;
            end
        end
        chk("r_progress", {31'b0, delivered >= 500}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
